// File: rtl/axis_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_rr_arbiter_pkg
//  Purpose  : Shared state encoding and width helpers for the AXIS arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package axis_rr_arbiter_pkg;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    // Port-index width; a 2-port arbiter still needs one bit of id.
    function automatic int id_width(input int ports);
        return (ports > 2) ? $clog2(ports) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// ============================================================================
//  Module   : rr_select
//  Purpose  : Combinational round-robin search starting just above 'last'.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int PORTS    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [PORTS-1:0]    request,
    input  logic [ID_WIDTH-1:0] last,
    output logic                any,
    output logic [ID_WIDTH-1:0] index
);

    // One spare bit so (last + 1 + offset) never overflows before the wrap.
    localparam int c_sw = ID_WIDTH + 1;

    logic [2*PORTS-1:0] w_dbl;
    logic [PORTS-1:0]   w_rot;
    logic [c_sw-1:0]    w_start;
    logic [c_sw-1:0]    w_off;
    logic [c_sw-1:0]    w_sum;

    assign any     = |request;
    assign w_dbl   = {request, request};
    assign w_start = {1'b0, last} + c_sw'(1);
    assign w_rot   = PORTS'(w_dbl >> w_start);

    always_comb begin
        w_off = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = c_sw'(k);
            end
        end
    end

    assign w_sum = w_start + w_off;
    assign index = (w_sum >= c_sw'(PORTS)) ? ID_WIDTH'(w_sum - c_sw'(PORTS))
                                           : ID_WIDTH'(w_sum);

endmodule
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axis_rr_arbiter
//  Purpose  : Round-robin AXI-Stream merger with per-grant burst cap.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_rr_arbiter
    import axis_rr_arbiter_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int PORTS            = 4,
    parameter int MAX_BURST        = 256,
    localparam int ID_WIDTH        = id_width(PORTS)
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]                  s_axis_tvalid,
    input  logic [PORTS-1:0]                  s_axis_tlast,
    output logic [PORTS-1:0]                  s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]       m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [ID_WIDTH-1:0]               m_axis_tid
);

    localparam int c_cw = cnt_width(MAX_BURST);

    logic [0:0]                  r_state;
    logic [ID_WIDTH-1:0]         r_grant;
    logic [ID_WIDTH-1:0]         r_last_grant;
    logic [c_cw-1:0]             r_count;

    logic                        w_any;
    logic [ID_WIDTH-1:0]         w_sel;
    logic                        w_granted;
    logic                        w_hs;
    logic                        w_sel_valid;
    logic                        w_sel_last;
    logic [AXIS_TDATA_WIDTH-1:0] w_sel_data;

    rr_select #(
        .PORTS    (PORTS),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_select (
        .request (s_axis_tvalid),
        .last    (r_last_grant),
        .any     (w_any),
        .index   (w_sel)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (r_grant == ID_WIDTH'(i)) begin
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
                w_sel_data  = s_axis_tdata[i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
            end
        end
    end

    assign w_granted     = (r_state == c_st_grant);
    assign m_axis_tvalid = w_granted & w_sel_valid;
    assign m_axis_tlast  = w_granted & w_sel_last;
    assign m_axis_tdata  = w_sel_data;
    assign m_axis_tid    = r_grant;
    assign w_hs          = m_axis_tvalid & m_axis_tready;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_ready
            assign s_axis_tready[gi] = w_granted && (r_grant == ID_WIDTH'(gi)) && m_axis_tready;
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= c_st_idle;
            r_grant      <= '0;
            r_last_grant <= ID_WIDTH'(PORTS - 1);
            r_count      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_grant      <= w_sel;
                        r_last_grant <= w_sel;
                        r_count      <= '0;
                        r_state      <= c_st_grant;
                    end
                end
                c_st_grant: begin
                    if (w_hs) begin
                        r_count <= r_count + c_cw'(1);
                        // Burst cap splits long packets so other ports cannot starve.
                        if (m_axis_tlast || (r_count == c_cw'(MAX_BURST - 1))) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_rr_arbiter
//  Purpose  : Self-checking bench for axis_rr_arbiter (4 ports, burst cap 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_rr_arbiter;

    localparam int W  = 32;
    localparam int P  = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct packed {
        logic [1:0]   tid;
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    typedef struct packed {
        logic [3:0]      mask;
        logic [2:0]      n;
        logic [3:0][1:0] order;
    } vec_t;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [P*W-1:0] s_axis_tdata;
    logic [P-1:0]   s_axis_tvalid;
    logic [P-1:0]   s_axis_tlast;
    logic [P-1:0]   s_axis_tready;
    logic [W-1:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           m_axis_tlast;
    logic [1:0]     m_axis_tid;

    beat_t      src_q[P][$];
    exp_t       exp_q[$];
    vec_t       vecs[6];
    logic [P-1:0] hold;
    logic       rst_drv;
    logic       mon_en;
    int         rdy_mode;
    int         scen_t;
    logic [P-1:0] smp_stready;
    logic       smp_mvalid;
    logic       smp_mlast;
    int         checks   = 0;
    int         failures = 0;

    axis_rr_arbiter #(
        .AXIS_TDATA_WIDTH (W),
        .PORTS            (P),
        .MAX_BURST        (MB)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic gen(input int port, input int n, input bit last_at_end);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.data = $urandom;
            bt.last = last_at_end && (b == n - 1);
            src_q[port].push_back(bt);
        end
    endtask

    task automatic exp_copy(input int port, input int first, input int count);
        exp_t e;
        for (int k = 0; k < count; k++) begin
            e.tid  = 2'(port);
            e.data = src_q[port][first+k].data;
            e.last = src_q[port][first+k].last;
            exp_q.push_back(e);
        end
    endtask

    // One clock: drive at negedge, sample 1 ns later, retire source beats after posedge.
    task automatic tick();
        logic [P-1:0] hs;
        exp_t e;
        @(negedge aclk);
        aresetn       = rst_drv;
        m_axis_tready = (rdy_mode == 0) ? 1'b1 : ((scen_t % 4 == 0) || (scen_t % 4 == 3));
        for (int i = 0; i < P; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tdata[i*W +: W]   = src_q[i][0].data;
                s_axis_tlast[i]          = src_q[i][0].last;
            end else begin
                s_axis_tvalid[i]         = 1'b0;
                s_axis_tdata[i*W +: W]   = '0;
                s_axis_tlast[i]          = 1'b0;
            end
        end
        #1;
        smp_stready = s_axis_tready;
        smp_mvalid  = m_axis_tvalid;
        smp_mlast   = m_axis_tlast;
        hs          = s_axis_tvalid & s_axis_tready;
        if (mon_en) begin
            if (m_axis_tvalid)
                chk("tready_route", 64'(s_axis_tready),
                    m_axis_tready ? 64'(4'b0001 << m_axis_tid) : 64'd0);
            else
                chk("no_stray_handshake", 64'(hs), 64'd0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_tid_data_last", 64'({m_axis_tid, m_axis_tdata, m_axis_tlast}), 64'(e));
                end
            end
        end
        @(posedge aclk);
        for (int i = 0; i < P; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        scen_t++;
    endtask

    task automatic run(input string name, input int exp_cycles);
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk(name, 64'(cyc), 64'(exp_cycles));
        exp_q.delete();
    endtask

    initial begin
        // {request mask, expected grant order}; last grant carries over row to row.
        vecs[0] = '{mask: 4'b1010, n: 3'd2, order: {2'd0, 2'd0, 2'd3, 2'd1}};
        vecs[1] = '{mask: 4'b0101, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd0}};
        vecs[2] = '{mask: 4'b1011, n: 3'd3, order: {2'd0, 2'd1, 2'd0, 2'd3}};
        vecs[3] = '{mask: 4'b1010, n: 3'd2, order: {2'd0, 2'd0, 2'd1, 2'd3}};
        vecs[4] = '{mask: 4'b0010, n: 3'd1, order: {2'd0, 2'd0, 2'd0, 2'd1}};
        vecs[5] = '{mask: 4'b1111, n: 3'd4, order: {2'd1, 2'd0, 2'd3, 2'd2}};

        aresetn       = 1'b0;
        rst_drv       = 1'b0;
        mon_en        = 1'b0;
        hold          = '0;
        rdy_mode      = 0;
        scen_t        = 0;
        m_axis_tready = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;

        tick();
        mon_en = 1'b1;

        // Four concurrent 3-beat packets, requested while still in reset.
        for (int p = 0; p < P; p++) gen(p, 3, 1'b1);
        for (int p = 0; p < P; p++) exp_copy(p, 0, 3);
        tick();
        chk("reset_m_tvalid", 64'(smp_mvalid), 64'd0);
        chk("reset_m_tlast", 64'(smp_mlast), 64'd0);
        chk("reset_s_tready", 64'(smp_stready), 64'd0);
        rst_drv = 1'b1;
        run("scen1_cycles", 16);

        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < P; p++) begin
                if (vecs[r].mask[p]) gen(p, 1, 1'b1);
            end
            for (int k = 0; k < int'(vecs[r].n); k++) exp_copy(int'(vecs[r].order[k]), 0, 1);
            run($sformatf("rr_vec%0d_cycles", r), 2 * int'(vecs[r].n));
        end

        // Ten beats with no tlast: split 4/4/2, grant then held waiting for more.
        gen(1, 10, 1'b0);
        exp_copy(1, 0, 10);
        run("burst_split_cycles", 13);
        gen(1, 1, 1'b1);
        exp_copy(1, 0, 1);
        run("burst_tail_cycles", 1);

        // Backpressure pattern 1,0,0,1 while a 5-beat packet crosses the cap.
        rdy_mode = 1;
        scen_t   = 0;
        gen(0, 5, 1'b1);
        exp_copy(0, 0, 5);
        run("backpressure_cycles", 12);
        rdy_mode = 0;

        // Reset during beat 2 of a port-2 packet; port 0 must win afterwards.
        gen(2, 5, 1'b1);
        gen(0, 2, 1'b1);
        exp_copy(2, 0, 2);
        exp_copy(0, 0, 2);
        exp_copy(2, 2, 3);
        tick();
        tick();
        rst_drv = 1'b0;
        tick();
        rst_drv = 1'b1;
        tick();
        chk("post_reset_s_tready", 64'(smp_stready), 64'd0);
        chk("post_reset_m_tvalid", 64'(smp_mvalid), 64'd0);
        run("post_reset_cycles", 6);

        // Granted port stalls for 5 cycles while port 0 waits.
        gen(1, 4, 1'b1);
        exp_copy(1, 0, 4);
        tick();
        tick();
        gen(0, 1, 1'b1);
        exp_copy(0, 0, 1);
        hold[1] = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("stall_m_tvalid", 64'(smp_mvalid), 64'd0);
            chk("stall_p0_tready", 64'(smp_stready[0]), 64'd0);
        end
        hold[1] = 1'b0;
        run("stall_resume_cycles", 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
